// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, instruction opcodes, execute-stage op encoding, front-end states.
package cpu_pkg;

  localparam int CPU_DATA_WIDTH     = 8;
  localparam int CPU_ADDR_WIDTH     = 8;
  localparam int CPU_REG_NUM        = 16;
  localparam int CPU_REG_ADDR_WIDTH = $clog2(CPU_REG_NUM);
  localparam int CPU_CMD_WIDTH      = 16;

  // Instruction word opcode field [15:12]
  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_MUL  = 4'h1;
  localparam logic [3:0] OPC_XNOR = 4'h2;
  localparam logic [3:0] OPC_MOV  = 4'h3;
  localparam logic [3:0] OPC_JUMP = 4'h4;
  localparam logic [3:0] OPC_LOAD = 4'h5;

  // Decoded op as seen by the execute stage
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MUL  = 3'd1,
    OP_XNOR = 3'd2,
    OP_MOV  = 3'd3,
    OP_JUMP = 3'd4,
    OP_LOAD = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_ISSUE   = 2'd2,
    S_BR_WAIT = 2'd3
  } fd_state_e;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational instruction word decoder; unused fields are driven to zero.
module cpu_instr_decoder
  import cpu_pkg::*;
(
  input  logic [CPU_CMD_WIDTH-1:0]      word,
  output logic [2:0]                    op,
  output logic [CPU_REG_ADDR_WIDTH-1:0] rs1,
  output logic [CPU_REG_ADDR_WIDTH-1:0] rs2,
  output logic [CPU_REG_ADDR_WIDTH-1:0] rd,
  output logic [CPU_DATA_WIDTH-1:0]     imm,
  output logic                          illegal
);

  // Split the word into fields according to its opcode
  always_comb begin
    op      = OP_NOP;
    rs1     = '0;
    rs2     = '0;
    rd      = '0;
    imm     = '0;
    illegal = 1'b0;
    case (word[15:12])
      OPC_NOP: ;
      OPC_MUL: begin
        op  = OP_MUL;
        rs1 = word[11:8];
        rs2 = word[7:4];
        rd  = word[3:0];
      end
      OPC_XNOR: begin
        op  = OP_XNOR;
        rs1 = word[11:8];
        rs2 = word[7:4];
        rd  = word[3:0];
      end
      OPC_MOV: begin
        op  = OP_MOV;
        rs1 = word[11:8];
        rd  = word[7:4];
      end
      OPC_JUMP: begin
        op  = OP_JUMP;
        imm = word[7:0];
      end
      OPC_LOAD: begin
        op  = OP_LOAD;
        rd  = word[11:8];
        imm = word[7:0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode front end: owns the PC, reads instruction memory, issues one decoded
// instruction at a time over valid/ready and applies JUMP redirects from execute.
module cpu_fetch_decode
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_NUM    = 16,
  parameter int CMD_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  output logic                       imem_rd_en,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  input  logic [CMD_WIDTH-1:0]       imem_rdata,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [2:0]                 dec_op,
  output logic [$clog2(REG_NUM)-1:0] dec_rs1,
  output logic [$clog2(REG_NUM)-1:0] dec_rs2,
  output logic [$clog2(REG_NUM)-1:0] dec_rd,
  output logic [DATA_WIDTH-1:0]      dec_imm,
  output logic                       dec_illegal,
  input  logic                       br_valid,
  input  logic                       br_taken
);

  localparam int REG_ADDR_WIDTH = $clog2(REG_NUM);

  fd_state_e                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]     pc;
  logic [ADDR_WIDTH-1:0]     target;
  logic                      rd_en;
  logic                      handshake;

  logic [2:0]                d_op;
  logic [REG_ADDR_WIDTH-1:0] d_rs1, d_rs2, d_rd;
  logic [DATA_WIDTH-1:0]     d_imm;
  logic                      d_illegal;

  cpu_instr_decoder u_decoder (
    .word    (imem_rdata),
    .op      (d_op),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .rd      (d_rd),
    .imm     (d_imm),
    .illegal (d_illegal)
  );

  assign handshake  = (state == S_ISSUE) && dec_ready;
  assign dec_valid  = (state == S_ISSUE);
  assign imem_addr  = pc;
  assign imem_rd_en = rd_en;

  // Next-state and read-strobe selection
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          rd_en     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (dec_ready) begin
          if (dec_op == OP_JUMP) begin
            state_nxt = S_BR_WAIT;
          end else if (en) begin
            rd_en     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_BR_WAIT: begin
        if (br_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, PC, branch target and decoded-output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      target      <= '0;
      dec_op      <= '0;
      dec_rs1     <= '0;
      dec_rs2     <= '0;
      dec_rd      <= '0;
      dec_imm     <= '0;
      dec_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        dec_op      <= d_op;
        dec_rs1     <= d_rs1;
        dec_rs2     <= d_rs2;
        dec_rd      <= d_rd;
        dec_imm     <= d_imm;
        dec_illegal <= d_illegal;
        pc          <= pc + ADDR_WIDTH'(1);
      end
      if (handshake && (dec_op == OP_JUMP)) begin
        target <= dec_imm;
      end
      if ((state == S_BR_WAIT) && br_valid && br_taken) begin
        pc <= target;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Scoreboard bench for cpu_fetch_decode: expected reads and decodes are queued by the
// stimulus, a negedge monitor compares them against what the DUT presents.
module tb_cpu_fetch_decode;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        dec_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        dec_valid;
  logic [2:0]  dec_op;
  logic [3:0]  dec_rs1, dec_rs2, dec_rd;
  logic [7:0]  dec_imm;
  logic        dec_illegal;

  cpu_fetch_decode #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .REG_NUM    (16),
    .CMD_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_op      (dec_op),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .dec_imm     (dec_imm),
    .dec_illegal (dec_illegal),
    .br_valid    (br_valid),
    .br_taken    (br_taken)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  typedef struct {
    logic [2:0] op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] imm;
    logic       ill;
  } exp_t;

  exp_t dq[$];
  int   aq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [2:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [3:0] rd, input logic [7:0] imm, input logic ill);
    exp_t e;
    e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  // Monitor: every read strobe and every presented decode is compared to the queues
  always @(negedge clk) begin : mon
    int   a;
    exp_t e;
    if (reset) begin
      if (imem_rd_en) begin
        checks++;
        if (aq.size() == 0) begin
          errors++;
          $display("FAIL read_addr unexpected read at %0d, none required", imem_addr);
        end else begin
          a = aq.pop_front();
          if (imem_addr !== a[7:0]) begin
            errors++;
            $display("FAIL read_addr got %0d required %0d", imem_addr, a);
          end
        end
      end
      if (dec_valid) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL decode unexpected dec_valid op=%0d", dec_op);
        end else begin
          e = dq[0];
          if ({dec_op, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_illegal} !==
              {e.op, e.rs1, e.rs2, e.rd, e.imm, e.ill}) begin
            errors++;
            $display("FAIL decode got op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ill=%0b required op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ill=%0b",
                     dec_op, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_illegal,
                     e.op, e.rs1, e.rs2, e.rd, e.imm, e.ill);
          end
          if (dec_ready) e = dq.pop_front();
        end
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (dec_valid !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    if (dec_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout got dec_valid=%0b required 1 within 40 cycles", dec_valid);
    end
  endtask

  // Accept one instruction after 'stall' ready-low cycles; optionally answer a JUMP
  task automatic issue(input int stall, input bit jump, input bit taken, input bit noise);
    wait_valid();
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        br_valid = 1'b1;
        br_taken = 1'b1;
      end
      cyc(1);
    end
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    dec_ready = 1'b1;
    cyc(1);
    dec_ready = 1'b0;
    if (jump) begin
      br_valid = 1'b1;
      br_taken = taken;
      cyc(1);
      br_valid = 1'b0;
      br_taken = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h510A;
    mem[1]   = 16'hF000;
    mem[2]   = 16'h3210;
    mem[3]   = 16'h1124;
    mem[4]   = 16'h2125;
    mem[5]   = 16'h4008;
    mem[6]   = 16'h0000;
    mem[7]   = 16'h40FF;
    mem[8]   = 16'h4005;
    mem[255] = 16'h5FEE;

    // Reset state
    cyc(2);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_op", dec_op, 0);
    chk("rst_rd", dec_rd, 0);
    chk("rst_imm", dec_imm, 0);
    chk("rst_illegal", dec_illegal, 0);

    // Main program: expected reads and decodes in order
    aq.push_back(0);
    dq.push_back(mk(3'd5, 4'd0, 4'd0, 4'd1, 8'h0A, 1'b0));  // 0: LOAD r1,0x0A
    aq.push_back(1);
    dq.push_back(mk(3'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1));  // 1: illegal
    aq.push_back(2);
    dq.push_back(mk(3'd3, 4'd2, 4'd0, 4'd1, 8'h00, 1'b0));  // 2: MOV
    aq.push_back(3);
    dq.push_back(mk(3'd1, 4'd1, 4'd2, 4'd4, 8'h00, 1'b0));  // 3: MUL
    aq.push_back(4);
    dq.push_back(mk(3'd2, 4'd1, 4'd2, 4'd5, 8'h00, 1'b0));  // 4: XNOR
    aq.push_back(5);
    dq.push_back(mk(3'd4, 4'd0, 4'd0, 4'd0, 8'h08, 1'b0));  // 5: JUMP 8 taken
    aq.push_back(8);
    dq.push_back(mk(3'd4, 4'd0, 4'd0, 4'd0, 8'h05, 1'b0));  // 8: JUMP 5 taken
    aq.push_back(5);
    dq.push_back(mk(3'd4, 4'd0, 4'd0, 4'd0, 8'h08, 1'b0));  // 5: JUMP 8 not taken
    aq.push_back(6);
    dq.push_back(mk(3'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));  // 6: NOP
    aq.push_back(7);
    dq.push_back(mk(3'd4, 4'd0, 4'd0, 4'd0, 8'hFF, 1'b0));  // 7: JUMP 255 taken
    aq.push_back(255);
    dq.push_back(mk(3'd5, 4'd0, 4'd0, 4'd15, 8'hEE, 1'b0)); // 255: LOAD r15,0xEE

    reset = 1'b1;
    cyc(1);
    en = 1'b1;
    cyc(1);
    chk("latency_fetch_valid", dec_valid, 0);
    cyc(1);
    chk("latency_issue_valid", dec_valid, 1);
    issue(0, 0, 0, 0);
    issue(0, 0, 0, 0);
    issue(0, 0, 0, 0);
    issue(3, 0, 0, 1);   // stalled MUL with stray br_valid
    issue(0, 0, 0, 0);
    issue(0, 1, 1, 0);
    issue(0, 1, 1, 0);
    issue(0, 1, 0, 0);
    issue(0, 0, 0, 0);
    issue(0, 1, 1, 0);   // read of 255 is strobed this cycle
    cyc(1);
    en = 1'b0;           // LOAD at 255 still completes, no further read
    issue(0, 0, 0, 0);
    cyc(2);
    chk("wrap_addr", imem_addr, 0);
    chk("stop_rd_en", imem_rd_en, 0);
    chk("stop_dec_valid", dec_valid, 0);
    chk("drain_dq", dq.size(), 0);
    chk("drain_aq", aq.size(), 0);

    // Reset while an instruction is presented
    aq.push_back(0);
    dq.push_back(mk(3'd5, 4'd0, 4'd0, 4'd1, 8'h0A, 1'b0));
    en = 1'b1;
    wait_valid();
    en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", dec_valid, 0);
    chk("rst_mid_addr", imem_addr, 0);
    dq.delete();
    aq.delete();

    // Reset while waiting for a branch result
    mem[0] = 16'h4033;
    cyc(1);
    reset = 1'b1;
    aq.push_back(0);
    dq.push_back(mk(3'd4, 4'd0, 4'd0, 4'd0, 8'h33, 1'b0));
    en = 1'b1;
    wait_valid();
    dec_ready = 1'b1;
    cyc(1);
    dec_ready = 1'b0;
    cyc(1);
    chk("brwait_valid", dec_valid, 0);
    chk("brwait_addr", imem_addr, 1);
    en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_br_valid", dec_valid, 0);
    chk("rst_br_addr", imem_addr, 0);
    dq.delete();
    aq.delete();

    // Restart from 0; the discarded branch must not redirect
    cyc(1);
    reset = 1'b1;
    aq.push_back(0);
    dq.push_back(mk(3'd4, 4'd0, 4'd0, 4'd0, 8'h33, 1'b0));
    aq.push_back(1);
    dq.push_back(mk(3'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1));
    en = 1'b1;
    issue(0, 1, 0, 0);
    cyc(1);
    en = 1'b0;
    issue(0, 0, 0, 0);
    cyc(3);
    chk("final_dq", dq.size(), 0);
    chk("final_aq", aq.size(), 0);
    chk("final_addr", imem_addr, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
